// File: rtl/dfp_arbiter.sv
// dfp_arbiter: shares one 256-bit line-granular dfp channel among the data cache
// (port 0), instruction cache (port 1) and line prefetcher (port 2).
// Optional aging: define DFP_ARB_AGING_EN to build per-port wait counters with
// age promotion; without it every age reads as 0 and arbitration is hazard rule
// followed by fixed priority 0 > 1 > 2.
module dfp_arbiter #(
    parameter int unsigned AGE_W     = 4,
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  req0_addr,
    input  logic         req0_read,
    input  logic         req0_write,
    input  logic [255:0] req0_wdata,
    output logic [255:0] req0_rdata,
    output logic         req0_resp,
    input  logic [31:0]  req1_addr,
    input  logic         req1_read,
    input  logic         req1_write,
    input  logic [255:0] req1_wdata,
    output logic [255:0] req1_rdata,
    output logic         req1_resp,
    input  logic [31:0]  req2_addr,
    input  logic         req2_read,
    input  logic         req2_write,
    input  logic [255:0] req2_wdata,
    output logic [255:0] req2_rdata,
    output logic         req2_resp,
    output logic [31:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);
    localparam int unsigned NP    = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 256;
    localparam int unsigned OFF_W = 5;
    localparam int unsigned IW    = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_grant;

    logic [AW-1:0]     w_addr  [NP];
    logic [LW-1:0]     w_wdata [NP];
    logic [AGE_W-1:0]  w_age   [NP];
    logic [NP-1:0]     w_rd;
    logic [NP-1:0]     w_wr;
    logic [NP-1:0]     w_pend;
    logic [NP-1:0]     w_pend_rd;

    logic              w_hazard;
    logic              w_old_vld;
    logic [IW-1:0]     w_old_idx;
    logic [AGE_W-1:0]  w_old_age;
    logic [IW-1:0]     w_fix_idx;
    logic [IW-1:0]     w_pick;

    logic [IW-1:0]     r_gnt;
    logic [AW-1:0]     r_addr;
    logic [LW-1:0]     r_wdata;
    logic              r_rd;
    logic              r_wr;

    assign w_addr[0]  = req0_addr;
    assign w_addr[1]  = req1_addr;
    assign w_addr[2]  = req2_addr;
    assign w_wdata[0] = req0_wdata;
    assign w_wdata[1] = req1_wdata;
    assign w_wdata[2] = req2_wdata;
    assign w_rd       = {req2_read, req1_read, req0_read};
    assign w_wr       = {req2_write, req1_write, req0_write};
    assign w_pend     = w_rd | w_wr;
    // A port asserting both read and write is a write; its read is ignored.
    assign w_pend_rd  = w_rd & ~w_wr;

    // Dcache write must reach memory before another port reads the same line.
    assign w_hazard = w_wr[0] &&
                      ((w_pend_rd[1] && (w_addr[1][AW-1:OFF_W] == w_addr[0][AW-1:OFF_W])) ||
                       (w_pend_rd[2] && (w_addr[2][AW-1:OFF_W] == w_addr[0][AW-1:OFF_W])));

    // Oldest pending port at or above the promotion threshold; ties to lowest index.
    always_comb begin
        w_old_vld = 1'b0;
        w_old_idx = '0;
        w_old_age = '0;
        for (int i = 0; i < NP; i++) begin
            if (w_pend[i] && (32'(w_age[i]) >= AGE_LIMIT) &&
                (!w_old_vld || (w_age[i] > w_old_age))) begin
                w_old_vld = 1'b1;
                w_old_idx = IW'(i);
                w_old_age = w_age[i];
            end
        end
    end

    // Fixed priority 0 > 1 > 2.
    always_comb begin
        w_fix_idx = IW'(2);
        if (w_pend[0]) begin
            w_fix_idx = IW'(0);
        end else if (w_pend[1]) begin
            w_fix_idx = IW'(1);
        end
    end

    assign w_pick = w_hazard ? IW'(0) : (w_old_vld ? w_old_idx : w_fix_idx);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: grant whenever idle with work pending, release on mem_resp.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_pend) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Capture the granted request; downstream strobes drop on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else if (w_grant) begin
            r_gnt   <= w_pick;
            r_addr  <= {w_addr[w_pick][AW-1:OFF_W], OFF_W'(0)};
            r_wdata <= w_wdata[w_pick];
            r_rd    <= ~w_wr[w_pick];
            r_wr    <= w_wr[w_pick];
        end else if ((r_state == S_BUSY) && mem_resp) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end
    end

`ifdef DFP_ARB_AGING_EN
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    logic [AGE_W-1:0] r_age [NP];

    // Wait counters: clear when idle, granted or in service; else saturate upward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (!w_pend[i] || (w_grant && (w_pick == IW'(i))) ||
                    ((r_state == S_BUSY) && (r_gnt == IW'(i)))) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_MAX) begin
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
        end
    end

    // Expose counters to the arbiter.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            w_age[i] = r_age[i];
        end
    end
`else
    // No counters: age reads as 0, so promotion never fires.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            w_age[i] = '0;
        end
    end
`endif

    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_read   = r_rd;
    assign mem_write  = r_wr;

    // Completion steered to the granted port only; read data is broadcast.
    assign req0_resp  = (r_state == S_BUSY) && mem_resp && (r_gnt == IW'(0));
    assign req1_resp  = (r_state == S_BUSY) && mem_resp && (r_gnt == IW'(1));
    assign req2_resp  = (r_state == S_BUSY) && mem_resp && (r_gnt == IW'(2));
    assign req0_rdata = mem_rdata;
    assign req1_rdata = mem_rdata;
    assign req2_rdata = mem_rdata;

endmodule

// File: tb/tb_dfp_arbiter.sv
// tb_dfp_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the three-port arbiter.
`timescale 1ns/1ps
module tb_dfp_arbiter;
    localparam int unsigned AGE_W     = 4;
    localparam int unsigned AGE_LIMIT = 8;
    localparam int          AGE_MAX   = (1 << AGE_W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  q_addr  [3];
    logic         q_rd    [3];
    logic         q_wr    [3];
    logic [255:0] q_wdata [3];
    logic [255:0] rdata0, rdata1, rdata2;
    logic         resp0, resp1, resp2;
    logic [31:0]  mem_addr;
    logic         mem_read, mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int errors = 0;
    int checks = 0;
    int mem_lat = 3;
    bit rsp_en = 1'b0;
    bit noise = 1'b0;
    bit lat_rand = 1'b0;
    int busy_cnt = 0;

    always #5 clk = ~clk;

    dfp_arbiter #(.AGE_W(AGE_W), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req0_addr(q_addr[0]), .req0_read(q_rd[0]), .req0_write(q_wr[0]),
        .req0_wdata(q_wdata[0]), .req0_rdata(rdata0), .req0_resp(resp0),
        .req1_addr(q_addr[1]), .req1_read(q_rd[1]), .req1_write(q_wr[1]),
        .req1_wdata(q_wdata[1]), .req1_rdata(rdata1), .req1_resp(resp1),
        .req2_addr(q_addr[2]), .req2_read(q_rd[2]), .req2_write(q_wr[2]),
        .req2_wdata(q_wdata[2]), .req2_rdata(rdata2), .req2_resp(resp2),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [2:0] resp_vec();
        return {resp2, resp1, resp0};
    endfunction

    function automatic logic [255:0] rdata_of(input int i);
        return (i == 0) ? rdata0 : ((i == 1) ? rdata1 : rdata2);
    endfunction

    // Memory model: one-cycle mem_resp after mem_lat busy cycles, optional stray pulses in idle.
    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_resp || !rsp_en) begin
                mem_resp = 1'b0;
                busy_cnt = 0;
            end else if (mem_read || mem_write) begin
                busy_cnt++;
                if (busy_cnt >= mem_lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rand_line();
                    busy_cnt  = 0;
                    if (lat_rand) mem_lat = $urandom_range(1, 4);
                end
            end else begin
                busy_cnt = 0;
                if (noise && $urandom_range(0, 7) == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rand_line();
                end
            end
        end
    end

    task automatic clear_reqs();
        for (int i = 0; i < 3; i++) begin
            q_addr[i] = '0; q_rd[i] = 1'b0; q_wr[i] = 1'b0; q_wdata[i] = '0;
        end
    endtask

    // Leaves the bench at posedge+1 with reset released and the DUT idle.
    task automatic do_reset();
        @(posedge clk); #1;
        rsp_en = 1'b0; noise = 1'b0; lat_rand = 1'b0; mem_lat = 3;
        clear_reqs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rsp_en = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got=%0b exp=0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%0b exp=0", mem_write); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 256'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (resp_vec() !== 3'b000) begin errors++; $display("FAIL reset_resp got=%b exp=000", resp_vec()); end
        rst = 1'b0;
        rsp_en = 1'b1;
        @(posedge clk); #2;
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b%b exp=00", mem_read, mem_write); end
        checks++; if (resp_vec() !== 3'b000) begin errors++; $display("FAIL post_reset_resp got=%b exp=000", resp_vec()); end
    endtask

    task automatic test_single_read();
        bit got = 1'b0;
        do_reset();
        mem_lat = 5;
        q_rd[1] = 1'b1; q_addr[1] = 32'h0000_1234;
        for (int k = 1; k <= 12 && !got; k++) begin
            @(posedge clk); #2;
            if (k == 1) begin
                checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL single_strobe got=%b%b exp=10", mem_read, mem_write); end
                checks++; if (mem_addr !== 32'h0000_1220) begin errors++; $display("FAIL single_addr got=%h exp=00001220", mem_addr); end
            end
            if (mem_resp) begin
                got = 1'b1;
                checks++; if (k != 5) begin errors++; $display("FAIL single_latency got=%0d exp=5", k); end
                checks++; if (resp_vec() !== 3'b010) begin errors++; $display("FAIL single_resp got=%b exp=010", resp_vec()); end
                checks++; if (rdata1 !== mem_rdata) begin errors++; $display("FAIL single_rdata got=%h exp=%h", rdata1, mem_rdata); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL single_timeout got=no_resp exp=resp"); end
        @(posedge clk); #1;
        q_rd[1] = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL single_release got=%b exp=0", mem_read); end
    endtask

    task automatic test_simultaneous();
        int order[$];
        bit drop[3];
        logic [2:0] rv;
        logic exp_rd;
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 3; i++) begin
            q_rd[i] = 1'b1; q_addr[i] = 32'h0000_4000 + 32'(i * 32'h100); drop[i] = 1'b0;
        end
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                for (int i = 0; i < 3; i++) if (drop[i]) begin q_rd[i] = 1'b0; drop[i] = 1'b0; end
            end
            #1;
            exp_rd = (c % 4 != 0) && (c < 12);
            checks++; if (mem_read !== exp_rd) begin errors++; $display("FAIL simul_mem_read cyc=%0d got=%b exp=%b", c, mem_read, exp_rd); end
            if (c % 4 == 1 && c < 12) begin
                checks++; if (mem_addr !== 32'h0000_4000 + 32'((c / 4) * 32'h100)) begin errors++; $display("FAIL simul_addr cyc=%0d got=%h exp=%h", c, mem_addr, 32'h0000_4000 + 32'((c / 4) * 32'h100)); end
            end
            rv = resp_vec();
            for (int i = 0; i < 3; i++) if (rv[i]) begin order.push_back(i); drop[i] = 1'b1; end
        end
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
            errors++; $display("FAIL simul_order got=%p exp='{0,1,2}", order);
        end
    endtask

    task automatic test_hazard();
        bit got = 1'b0;
        logic [255:0] w;
        logic [2:0] rv;
        do_reset();
        mem_lat = 10;
        w = rand_line();
        q_rd[0] = 1'b1; q_addr[0] = 32'h0000_0100;
        q_rd[1] = 1'b1; q_addr[1] = 32'h8000_0040;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clk); #2;
            rv = resp_vec();
            if (rv[0]) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL hazard_first_timeout got=no_resp exp=resp"); end
        @(posedge clk); #1;
        q_rd[0] = 1'b0; q_wr[0] = 1'b1; q_addr[0] = 32'h8000_0044; q_wdata[0] = w; mem_lat = 3;
        @(posedge clk); #2;
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL hazard_strobe got=%b%b exp=01", mem_read, mem_write); end
        checks++; if (mem_addr !== 32'h8000_0040) begin errors++; $display("FAIL hazard_addr got=%h exp=80000040", mem_addr); end
        checks++; if (mem_wdata !== w) begin errors++; $display("FAIL hazard_wdata got=%h exp=%h", mem_wdata, w); end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (mem_resp) begin
                got = 1'b1;
                checks++; if (resp_vec() !== 3'b001) begin errors++; $display("FAIL hazard_resp got=%b exp=001", resp_vec()); end
            end else begin
                @(posedge clk); #2;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL hazard_write_timeout got=no_resp exp=resp"); end
        @(posedge clk); #1;
        q_wr[0] = 1'b0;
        @(posedge clk); #2;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h8000_0040) begin errors++; $display("FAIL hazard_port1_grant got=%b/%h exp=1/80000040", mem_read, mem_addr); end
    endtask

    task automatic test_isolation();
        logic [255:0] w;
        do_reset();
        mem_lat = 6;
        w = rand_line();
        q_wr[0] = 1'b1; q_addr[0] = 32'h0000_2468; q_wdata[0] = w;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            q_addr[0] = $urandom; q_wdata[0] = rand_line();
            #1;
            checks++; if (mem_addr !== 32'h0000_2460 || mem_write !== 1'b1) begin errors++; $display("FAIL isol_addr cyc=%0d got=%h/%b exp=00002460/1", c, mem_addr, mem_write); end
            checks++; if (mem_wdata !== w) begin errors++; $display("FAIL isol_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, w); end
        end
    endtask

    task automatic test_aging();
        int n0 = 0;
        bit seen2 = 1'b0;
        bit bump = 1'b0;
        logic [2:0] rv;
        do_reset();
        mem_lat = 3;
        q_rd[2] = 1'b1; q_addr[2] = 32'h0000_0200;
        q_rd[0] = 1'b1; q_addr[0] = 32'h0000_1000;
        for (int c = 1; c <= 60 && !seen2; c++) begin
            @(posedge clk); #1;
            if (bump) begin q_addr[0] = 32'h0000_1000 + 32'(n0 * 32); bump = 1'b0; end
            #1;
            rv = resp_vec();
            if (mem_read && mem_addr == 32'h0000_0200) seen2 = 1'b1;
            else if (rv[0]) begin n0++; bump = 1'b1; end
        end
`ifdef DFP_ARB_AGING_EN
        checks++; if (!seen2) begin errors++; $display("FAIL aging_grant got=starved exp=granted"); end
        checks++; if (n0 != int'((AGE_LIMIT + 3) / 4)) begin errors++; $display("FAIL aging_port0_count got=%0d exp=%0d", n0, (AGE_LIMIT + 3) / 4); end
`else
        checks++; if (seen2) begin errors++; $display("FAIL starve_grant got=granted exp=starved"); end
        checks++; if (n0 != 15) begin errors++; $display("FAIL starve_port0_count got=%0d exp=15", n0); end
`endif
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        mem_lat = 20;
        q_wr[1] = 1'b1; q_addr[1] = 32'h0000_3333; q_wdata[1] = rand_line();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", mem_write); end
        #1 rst = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rstmid_strobe got=%b%b exp=00", mem_read, mem_write); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 256'h0) begin errors++; $display("FAIL rstmid_data got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        checks++; if (resp_vec() !== 3'b000) begin errors++; $display("FAIL rstmid_resp got=%b exp=000", resp_vec()); end
        clear_reqs();
        @(posedge clk); #1;
        rst = 1'b0; mem_lat = 2;
        q_rd[2] = 1'b1; q_addr[2] = 32'h0000_0abc;
        @(posedge clk); #2;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_0aa0) begin errors++; $display("FAIL rstmid_regrant got=%b/%h exp=1/00000aa0", mem_read, mem_addr); end
    endtask

    task automatic test_random();
        bit           m_busy = 1'b0;
        int           m_gnt = 0;
        logic [31:0]  m_addr = '0;
        bit           m_wr = 1'b0;
        logic [255:0] m_wd = '0;
        int           m_age[3];
        bit           done[3];
        bit           pend[3];
        int           g, op;
        logic [2:0]   exp_rv;
        do_reset();
        noise = 1'b1; lat_rand = 1'b1; mem_lat = 2;
        for (int i = 0; i < 3; i++) begin m_age[i] = 0; done[i] = 1'b0; end
        for (int c = 0; c < 1500; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    q_rd[i] = 1'b0; q_wr[i] = 1'b0; done[i] = 1'b0;
                end else if (!(q_rd[i] || q_wr[i])) begin
                    if ($urandom_range(0, 2) == 0) begin
                        op = $urandom_range(0, 2);
                        q_rd[i] = (op != 1); q_wr[i] = (op != 0);
                        q_addr[i] = 32'h8000_0000 | 32'($urandom_range(0, 3) << 5) | 32'($urandom_range(0, 31));
                        q_wdata[i] = rand_line();
                    end
                end else if (i == 2 && !(m_busy && m_gnt == 2) && $urandom_range(0, 15) == 0) begin
                    q_rd[2] = 1'b0; q_wr[2] = 1'b0;
                end
            end
            #1;
            exp_rv = (m_busy && mem_resp) ? 3'(1 << m_gnt) : 3'b000;
            checks++; if (mem_read !== (m_busy && !m_wr) || mem_write !== (m_busy && m_wr)) begin errors++; $display("FAIL rnd_strobe cyc=%0d got=%b%b exp=%b%b", c, mem_read, mem_write, m_busy && !m_wr, m_busy && m_wr); end
            checks++; if (resp_vec() !== exp_rv) begin errors++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", c, resp_vec(), exp_rv); end
            if (m_busy) begin
                checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, mem_addr, m_addr); end
                if (m_wr) begin
                    checks++; if (mem_wdata !== m_wd) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, m_wd); end
                end
                if (mem_resp) begin
                    checks++; if (rdata_of(m_gnt) !== mem_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rdata_of(m_gnt), mem_rdata); end
                    done[m_gnt] = 1'b1;
                end
            end
            // Reference arbitration for the decision taken at the coming edge.
            for (int i = 0; i < 3; i++) pend[i] = q_rd[i] || q_wr[i];
            g = -1;
            if (!m_busy && (pend[0] || pend[1] || pend[2])) begin
                if (q_wr[0] && ((q_rd[1] && !q_wr[1] && q_addr[1][31:5] == q_addr[0][31:5]) ||
                                (q_rd[2] && !q_wr[2] && q_addr[2][31:5] == q_addr[0][31:5]))) g = 0;
`ifdef DFP_ARB_AGING_EN
                if (g < 0) begin
                    for (int i = 0; i < 3; i++)
                        if (pend[i] && m_age[i] >= int'(AGE_LIMIT) && (g < 0 || m_age[i] > m_age[g])) g = i;
                end
`endif
                if (g < 0) begin
                    for (int i = 0; i < 3; i++) if (pend[i] && g < 0) g = i;
                end
            end
`ifdef DFP_ARB_AGING_EN
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] || g == i || (m_busy && m_gnt == i)) m_age[i] = 0;
                else if (m_age[i] < AGE_MAX) m_age[i]++;
            end
`endif
            if (g >= 0) begin
                m_busy = 1'b1; m_gnt = g; m_addr = {q_addr[g][31:5], 5'b0};
                m_wr = q_wr[g]; m_wd = q_wdata[g];
            end else if (m_busy && mem_resp) begin
                m_busy = 1'b0;
            end
        end
        noise = 1'b0; lat_rand = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_hazard();
        test_isolation();
        test_aging();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
